avm_read_arbiter: RTL and testbench
===================================

# avm_read_arbiter

Shares the single FPGA-to-HPS Avalon-MM read master (29-bit word address, 64-bit data) between two fabric requesters. Requester 0 is the APU sample fetcher and requester 1 is the PPU/auxiliary fetch path. The block selects a winner, owns and holds the master's request lines under `avm_waitrequest`, and tracks up to `MAX_OUTSTANDING` pipelined reads. Each returning `avm_readdatavalid` beat is steered back to the requester that issued it, in order.

## Interface
- `MAX_OUTSTANDING`, 4: maximum accepted-but-unreturned reads; sets the ID FIFO depth; power of two, 2..16.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `rq0_addr`, `rq1_addr`  in  29 each  requester word address.
- `rq0_read`, `rq1_read`  in  1 each  read request; held with a stable address until the matching waitrequest is low.
- `rq0_waitrequest`, `rq1_waitrequest`  out  1 each  low for the cycle the request is taken.
- `rq0_readdata`, `rq1_readdata`  out  64 each  returned data, a copy of `avm_readdata`.
- `rq0_readdatavalid`, `rq1_readdatavalid`  out  1 each  return strobe for that requester.
- `avm_addr`  out  29  master address; registered.
- `avm_read`  out  1  master read; registered.
- `avm_readdata`  in  64  master return data.
- `avm_readdatavalid`  in  1  master return strobe.
- `avm_waitrequest`  in  1  master stall.
- `outstanding`  out  $clog2(MAX_OUTSTANDING)+1  current ID FIFO occupancy.

## Operation
- Issue register: `avm_read` and `avm_addr`, forming two states.
  - IDLE: `avm_read` = 0.
  - ISSUE: `avm_read` = 1.
  - The address is held constant for as long as `avm_waitrequest` = 1.
- Accept: `avm_read` & !`avm_waitrequest`. On accept, the ID of the requester that owns the issue register is pushed into the ID FIFO.
- Load condition: (!`avm_read` | accept) & (`outstanding` + `avm_read`) < `MAX_OUTSTANDING` & (`rq0_read` | `rq1_read`). A same-cycle return is not credited.
- On load:
  - The winner's address and ID are latched into the issue register.
  - `avm_read` is set to 1.
  - The winner's waitrequest is driven low for that cycle only.
  - `last_grant` is updated to the winner.
- If accept occurs with no load, the block returns to IDLE.
- Arbitration without the macro is round-robin:
  - A lone requester wins.
  - When both request, the one that is not `last_grant` wins.
- Waitrequest: any requester that requests and does not win sees its waitrequest = 1. A requester that is not requesting also sees waitrequest = 1.
- Return path:
  - `rqN_readdata` = `avm_readdata`, combinational.
  - `rqN_readdatavalid` = `avm_readdatavalid` & FIFO non-empty & head ID == N.
  - Each returned beat pops the FIFO.
- Simultaneous accept and return: push and pop in the same cycle, so occupancy is unchanged.
- A return while the FIFO is empty is a protocol error. The beat is dropped and occupancy stays 0, with no underflow.
- The FIFO cannot overflow, because of the load condition.

## Timing
- Reset values:
  - `avm_read` = 0, `avm_addr` = 0.
  - `outstanding` = 0; the FIFO is empty.
  - `last_grant` = 1, so requester 0 wins the first tie.
  - Both `rqN_waitrequest` are forced to 1 and both `rqN_readdatavalid` are forced to 0 while `rst_n` = 0.
- Request latency: a requester's waitrequest goes low in cycle T and its request appears on `avm_read`/`avm_addr` in cycle T+1.
- Back-to-back throughput: with `avm_waitrequest` = 0 and credit available, one request is issued per cycle.
- Return latency: 0 cycles from `avm_readdatavalid` to `rqN_readdatavalid`.
- Reset mid-operation: the issue register and FIFO are cleared and in-flight IDs are lost. Stray post-reset returns hit the empty-FIFO rule and are dropped.
- The grant never changes while `avm_read` = 1 and `avm_waitrequest` = 1.

## Configuration
- `AVM_ARB_FIXED_PRIO_EN`
  - Defined: requester 0 always wins when both request. `last_grant` is still maintained but is not used. This guarantees APU latency at the cost of requester-1 fairness.
  - Undefined: round-robin as described under Operation.

## Structure
- Package `avm_arb_pkg`:
  - `AVM_ADDR_W` = 29, `AVM_DATA_W` = 64.
  - `typedef logic req_id_t` (the requester index).
  - `typedef enum {ARB_IDLE, ARB_ISSUE} arb_state_t`.
- Sub-module `avm_id_fifo`: synchronous FIFO of `req_id_t`, depth `MAX_OUTSTANDING`, with push, pop, head, count, and an empty-pop guard. The arbiter and issue register stay in `avm_read_arbiter`.

## Test plan
- Lone requester, pipelined reads:
  - Stimulus: `rq0_read` with addr 0x100; `avm_waitrequest` = 0; data 0xDEAD_BEEF_0000_0001 returned after 3 cycles.
  - Response: `avm_addr` = 0x100 one cycle after `rq0_waitrequest` goes low; `rq0_readdatavalid` pulses with that data; `rq1_readdatavalid` stays 0.
- Contention, round-robin:
  - Stimulus: both requesters assert continuously; `avm_waitrequest` = 0.
  - Response: grants run 0,1,0,1; returns in the same order go to rq0, rq1, rq0, rq1.
- Credit limit:
  - Stimulus: `MAX_OUTSTANDING` = 4; no returns.
  - Response: exactly 4 accepts, then both waitrequests stay 1. After one return, exactly one more load occurs.
- Stall hold:
  - Stimulus: `avm_waitrequest` = 1 for 5 cycles while in ISSUE.
  - Response: `avm_addr` and the grant are stable throughout and no new waitrequest goes low. One accept occurs when the stall drops.
- Edge cases:
  - Stimulus: `rst_n` low with 3 reads outstanding, then 3 stray `avm_readdatavalid` beats.
  - Response: outputs return to reset values, no `rqN_readdatavalid` pulses, and `outstanding` stays 0.
  - Stimulus: a same-cycle accept and return.
  - Response: `outstanding` is unchanged.
- With `AVM_ARB_FIXED_PRIO_EN` defined:
  - Stimulus: both requesters assert continuously.
  - Response: every grant goes to rq0.

Source files
------------

// File: rtl/avm_arb_pkg.sv
// Shared types and widths for the FPGA-to-HPS Avalon-MM read arbiter.
package avm_arb_pkg;
  localparam int AVM_ADDR_W = 29;
  localparam int AVM_DATA_W = 64;

  typedef logic req_id_t;
  typedef enum logic {ARB_IDLE, ARB_ISSUE} arb_state_t;
endpackage

// File: rtl/avm_id_fifo.sv
// Requester-ID FIFO: one entry per accepted read, popped per returned beat.
// A pop while empty is ignored, so a stray return can never underflow it.
module avm_id_fifo
  import avm_arb_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  req_id_t       push_id,
  input  logic          pop,
  output req_id_t       head,
  output logic [CW-1:0] count,
  output logic          empty
);

  req_id_t [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]       wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]       count_q, count_d;
  logic                full, do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem_q[rd_q];
  assign count   = count_q;

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q + CW'(do_push) - CW'(do_pop);
    if (do_push) begin
      mem_d[wr_q] = push_id;
      wr_d        = wr_q + AW'(1);
    end
    if (do_pop) rd_d = rd_q + AW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/avm_read_arbiter.sv
// Two-requester arbiter for a pipelined Avalon-MM read master with in-order return steering.
// Define AVM_ARB_FIXED_PRIO_EN to give requester 0 absolute priority instead of round-robin.
module avm_read_arbiter
  import avm_arb_pkg::*;
#(
  parameter int  MAX_OUTSTANDING = 4,
  localparam int CW              = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [AVM_ADDR_W-1:0] rq0_addr,
  input  logic                  rq0_read,
  output logic                  rq0_waitrequest,
  output logic [AVM_DATA_W-1:0] rq0_readdata,
  output logic                  rq0_readdatavalid,
  input  logic [AVM_ADDR_W-1:0] rq1_addr,
  input  logic                  rq1_read,
  output logic                  rq1_waitrequest,
  output logic [AVM_DATA_W-1:0] rq1_readdata,
  output logic                  rq1_readdatavalid,
  output logic [AVM_ADDR_W-1:0] avm_addr,
  output logic                  avm_read,
  input  logic [AVM_DATA_W-1:0] avm_readdata,
  input  logic                  avm_readdatavalid,
  input  logic                  avm_waitrequest,
  output logic [CW-1:0]         outstanding
);

  arb_state_t            state_q, state_d;
  logic [AVM_ADDR_W-1:0] addr_q, addr_d;
  req_id_t               id_q, id_d;
  req_id_t               last_grant_q, last_grant_d;

  req_id_t               win_id, head_id;
  logic [AVM_ADDR_W-1:0] win_addr;
  logic [CW:0]           occ_sum;
  logic [CW-1:0]         fifo_count;
  logic                  accept, credit_ok, load, fifo_empty, ret_ok;

  assign avm_read    = (state_q == ARB_ISSUE);
  assign avm_addr    = addr_q;
  assign outstanding = fifo_count;

  // The read sitting in the issue register consumes a credit; returns this cycle do not free one.
  assign accept    = avm_read & ~avm_waitrequest;
  assign occ_sum   = {1'b0, fifo_count} + {{CW{1'b0}}, avm_read};
  assign credit_ok = (occ_sum < (CW+1)'(MAX_OUTSTANDING));
  assign load      = (~avm_read | accept) & credit_ok & (rq0_read | rq1_read);

  always_comb begin
    win_id = 1'b0;
    if (rq0_read && rq1_read) begin
`ifdef AVM_ARB_FIXED_PRIO_EN
      win_id = 1'b0;
`else
      win_id = ~last_grant_q;
`endif
    end else if (rq1_read) begin
      win_id = 1'b1;
    end
    win_addr = win_id ? rq1_addr : rq0_addr;
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    if (load) begin
      state_d      = ARB_ISSUE;
      addr_d       = win_addr;
      id_d         = win_id;
      last_grant_d = win_id;
    end else if (accept) begin
      state_d = ARB_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      addr_q       <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
    end
  end

  avm_id_fifo #(.DEPTH(MAX_OUTSTANDING)) u_id_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (accept),
    .push_id (id_q),
    .pop     (avm_readdatavalid),
    .head    (head_id),
    .count   (fifo_count),
    .empty   (fifo_empty)
  );

  assign rq0_waitrequest = ~(rst_n & load & (win_id == 1'b0));
  assign rq1_waitrequest = ~(rst_n & load & (win_id == 1'b1));

  assign ret_ok            = rst_n & avm_readdatavalid & ~fifo_empty;
  assign rq0_readdatavalid = ret_ok & (head_id == 1'b0);
  assign rq1_readdatavalid = ret_ok & (head_id == 1'b1);
  assign rq0_readdata      = avm_readdata;
  assign rq1_readdata      = avm_readdata;

endmodule

// File: tb/tb_avm_read_arbiter.sv
// Directed bench for avm_read_arbiter: drive on the falling edge, sample 1ns later.
module tb_avm_read_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [28:0] rq0_addr, rq1_addr, avm_addr;
  logic        rq0_read, rq1_read, rq0_waitrequest, rq1_waitrequest;
  logic [63:0] rq0_readdata, rq1_readdata, avm_readdata;
  logic        rq0_readdatavalid, rq1_readdatavalid;
  logic        avm_read, avm_readdatavalid, avm_waitrequest;
  logic [2:0]  outstanding;

  int n_cmp = 0;
  int n_err = 0;

  avm_read_arbiter #(.MAX_OUTSTANDING(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .rq0_addr(rq0_addr), .rq0_read(rq0_read), .rq0_waitrequest(rq0_waitrequest),
    .rq0_readdata(rq0_readdata), .rq0_readdatavalid(rq0_readdatavalid),
    .rq1_addr(rq1_addr), .rq1_read(rq1_read), .rq1_waitrequest(rq1_waitrequest),
    .rq1_readdata(rq1_readdata), .rq1_readdatavalid(rq1_readdatavalid),
    .avm_addr(avm_addr), .avm_read(avm_read), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid), .avm_waitrequest(avm_waitrequest),
    .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rq0_read = 0; rq1_read = 0; rq0_addr = '0; rq1_addr = '0;
    avm_readdata = '0; avm_readdatavalid = 0; avm_waitrequest = 0;
  endtask

  task automatic do_reset();
    cyc(); rst_n = 0; idle_inputs();
    cyc(); rst_n = 1;
  endtask

  task automatic test_reset();
    cyc(); rst_n = 0; idle_inputs();
    rq0_read = 1; rq1_read = 1; avm_readdatavalid = 1; #1;
    n_cmp++; if (rq0_waitrequest !== 1'b1) begin n_err++; $display("FAIL rst_wr0 got %b exp 1", rq0_waitrequest); end
    n_cmp++; if (rq1_waitrequest !== 1'b1) begin n_err++; $display("FAIL rst_wr1 got %b exp 1", rq1_waitrequest); end
    n_cmp++; if ({rq1_readdatavalid, rq0_readdatavalid} !== 2'b00) begin n_err++; $display("FAIL rst_rdv got %b exp 00", {rq1_readdatavalid, rq0_readdatavalid}); end
    cyc(); #1;
    n_cmp++; if (avm_read !== 1'b0) begin n_err++; $display("FAIL rst_avm_read got %b exp 0", avm_read); end
    n_cmp++; if (avm_addr !== 29'h0) begin n_err++; $display("FAIL rst_avm_addr got %h exp 0", avm_addr); end
    n_cmp++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL rst_outstanding got %0d exp 0", outstanding); end
    idle_inputs(); rst_n = 1;
  endtask

  task automatic test_lone();
    do_reset();
    cyc(); rq0_read = 1; rq0_addr = 29'h100; #1;
    n_cmp++; if (rq0_waitrequest !== 1'b0) begin n_err++; $display("FAIL lone_wr0 got %b exp 0", rq0_waitrequest); end
    n_cmp++; if (rq1_waitrequest !== 1'b1) begin n_err++; $display("FAIL lone_wr1 got %b exp 1", rq1_waitrequest); end
    cyc(); rq0_read = 0; #1;
    n_cmp++; if (avm_read !== 1'b1) begin n_err++; $display("FAIL lone_avm_read got %b exp 1", avm_read); end
    n_cmp++; if (avm_addr !== 29'h100) begin n_err++; $display("FAIL lone_avm_addr got %h exp 100", avm_addr); end
    cyc(); #1;
    n_cmp++; if (avm_read !== 1'b0) begin n_err++; $display("FAIL lone_idle got %b exp 0", avm_read); end
    n_cmp++; if (outstanding !== 3'd1) begin n_err++; $display("FAIL lone_outstanding got %0d exp 1", outstanding); end
    cyc();
    cyc(); avm_readdatavalid = 1; avm_readdata = 64'hDEAD_BEEF_0000_0001; #1;
    n_cmp++; if (rq0_readdatavalid !== 1'b1) begin n_err++; $display("FAIL lone_rdv0 got %b exp 1", rq0_readdatavalid); end
    n_cmp++; if (rq0_readdata !== 64'hDEAD_BEEF_0000_0001) begin n_err++; $display("FAIL lone_data got %h exp deadbeef00000001", rq0_readdata); end
    n_cmp++; if (rq1_readdatavalid !== 1'b0) begin n_err++; $display("FAIL lone_rdv1 got %b exp 0", rq1_readdatavalid); end
    cyc(); avm_readdatavalid = 0; #1;
    n_cmp++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL lone_drain got %0d exp 0", outstanding); end
  endtask

  task automatic test_contention();
    logic g [4];
    logic [28:0] ea;
`ifdef AVM_ARB_FIXED_PRIO_EN
    g = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    g = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    do_reset();
    for (int c = 0; c < 5; c++) begin
      cyc(); rq0_read = 1; rq0_addr = 29'h200; rq1_read = 1; rq1_addr = 29'h300; #1;
      if (c < 4) begin
        n_cmp++; if ({rq1_waitrequest, rq0_waitrequest} !== (g[c] ? 2'b01 : 2'b10)) begin n_err++; $display("FAIL cont_grant%0d got %b exp %b", c, {rq1_waitrequest, rq0_waitrequest}, (g[c] ? 2'b01 : 2'b10)); end
      end else begin
        n_cmp++; if ({rq1_waitrequest, rq0_waitrequest} !== 2'b11) begin n_err++; $display("FAIL cont_credit_stop got %b exp 11", {rq1_waitrequest, rq0_waitrequest}); end
      end
      if (c > 0) begin
        ea = g[c-1] ? 29'h300 : 29'h200;
        n_cmp++; if (avm_addr !== ea) begin n_err++; $display("FAIL cont_addr%0d got %h exp %h", c-1, avm_addr, ea); end
      end
    end
    cyc(); rq0_read = 0; rq1_read = 0; #1;
    n_cmp++; if (outstanding !== 3'd4) begin n_err++; $display("FAIL cont_outstanding got %0d exp 4", outstanding); end
    for (int c = 0; c < 4; c++) begin
      cyc(); avm_readdatavalid = 1; avm_readdata = 64'h1000 + 64'(c); #1;
      n_cmp++; if ({rq1_readdatavalid, rq0_readdatavalid} !== (g[c] ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL cont_ret%0d got %b exp %b", c, {rq1_readdatavalid, rq0_readdatavalid}, (g[c] ? 2'b10 : 2'b01)); end
    end
    cyc(); avm_readdatavalid = 0; #1;
    n_cmp++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL cont_drain got %0d exp 0", outstanding); end
  endtask

  task automatic test_credit();
    int loads;
    do_reset();
    loads = 0;
    for (int c = 0; c < 10; c++) begin
      cyc(); rq1_read = 1; rq1_addr = 29'h400; #1;
      if (!rq1_waitrequest) loads++;
      n_cmp++; if (rq0_waitrequest !== 1'b1) begin n_err++; $display("FAIL credit_wr0_c%0d got %b exp 1", c, rq0_waitrequest); end
    end
    n_cmp++; if (loads !== 4) begin n_err++; $display("FAIL credit_loads got %0d exp 4", loads); end
    n_cmp++; if (outstanding !== 3'd4) begin n_err++; $display("FAIL credit_full got %0d exp 4", outstanding); end
    cyc(); avm_readdatavalid = 1; avm_readdata = 64'h2222; #1;
    n_cmp++; if (rq1_readdatavalid !== 1'b1) begin n_err++; $display("FAIL credit_ret got %b exp 1", rq1_readdatavalid); end
    loads = rq1_waitrequest ? 0 : 1;
    for (int c = 0; c < 8; c++) begin
      cyc(); avm_readdatavalid = 0; #1;
      if (!rq1_waitrequest) loads++;
    end
    n_cmp++; if (loads !== 1) begin n_err++; $display("FAIL credit_reload got %0d exp 1", loads); end
    n_cmp++; if (outstanding !== 3'd4) begin n_err++; $display("FAIL credit_refull got %0d exp 4", outstanding); end
    cyc(); rq1_read = 0;
    for (int c = 0; c < 4; c++) begin
      cyc(); avm_readdatavalid = 1; #1;
      n_cmp++; if (rq1_readdatavalid !== 1'b1) begin n_err++; $display("FAIL credit_drain%0d got %b exp 1", c, rq1_readdatavalid); end
    end
    cyc(); avm_readdatavalid = 0; #1;
    n_cmp++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL credit_empty got %0d exp 0", outstanding); end
  endtask

  task automatic test_stall();
    do_reset();
    cyc(); avm_waitrequest = 1; rq0_read = 1; rq0_addr = 29'h500; #1;
    n_cmp++; if (rq0_waitrequest !== 1'b0) begin n_err++; $display("FAIL stall_load got %b exp 0", rq0_waitrequest); end
    for (int c = 0; c < 5; c++) begin
      cyc(); rq0_read = 0; rq1_read = 1; rq1_addr = 29'h600; #1;
      n_cmp++; if (avm_read !== 1'b1 || avm_addr !== 29'h500) begin n_err++; $display("FAIL stall_hold%0d got %b/%h exp 1/500", c, avm_read, avm_addr); end
      n_cmp++; if ({rq1_waitrequest, rq0_waitrequest} !== 2'b11) begin n_err++; $display("FAIL stall_wr%0d got %b exp 11", c, {rq1_waitrequest, rq0_waitrequest}); end
    end
    cyc(); avm_waitrequest = 0; #1;
    n_cmp++; if (rq1_waitrequest !== 1'b0) begin n_err++; $display("FAIL stall_release got %b exp 0", rq1_waitrequest); end
    cyc(); rq1_read = 0; #1;
    n_cmp++; if (outstanding !== 3'd1 || avm_addr !== 29'h600) begin n_err++; $display("FAIL stall_accept got %0d/%h exp 1/600", outstanding, avm_addr); end
    cyc(); avm_readdatavalid = 1; #1;
    n_cmp++; if ({rq1_readdatavalid, rq0_readdatavalid} !== 2'b01) begin n_err++; $display("FAIL stall_ret0 got %b exp 01", {rq1_readdatavalid, rq0_readdatavalid}); end
    cyc(); #1;
    n_cmp++; if ({rq1_readdatavalid, rq0_readdatavalid} !== 2'b10) begin n_err++; $display("FAIL stall_ret1 got %b exp 10", {rq1_readdatavalid, rq0_readdatavalid}); end
    cyc(); avm_readdatavalid = 0;
  endtask

  task automatic test_same_cycle();
    do_reset();
    cyc(); rq0_read = 1; rq0_addr = 29'h700;
    cyc(); rq0_read = 0;
    cyc(); rq0_read = 1; rq0_addr = 29'h708; #1;
    n_cmp++; if (outstanding !== 3'd1) begin n_err++; $display("FAIL same_pre got %0d exp 1", outstanding); end
    cyc(); rq0_read = 0; avm_readdatavalid = 1; avm_readdata = 64'h3333; #1;
    n_cmp++; if (rq0_readdatavalid !== 1'b1 || avm_read !== 1'b1) begin n_err++; $display("FAIL same_both got %b/%b exp 1/1", rq0_readdatavalid, avm_read); end
    cyc(); avm_readdatavalid = 0; #1;
    n_cmp++; if (outstanding !== 3'd1) begin n_err++; $display("FAIL same_occ got %0d exp 1", outstanding); end
    cyc(); avm_readdatavalid = 1;
    cyc(); avm_readdatavalid = 0; #1;
    n_cmp++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL same_drain got %0d exp 0", outstanding); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      cyc(); rq0_read = 1; rq0_addr = 29'h800 + 29'(c);
    end
    cyc(); rq0_read = 0;
    cyc(); #1;
    n_cmp++; if (outstanding !== 3'd3) begin n_err++; $display("FAIL mid_pre got %0d exp 3", outstanding); end
    rst_n = 0; rq0_read = 1; #1;
    n_cmp++; if (rq0_waitrequest !== 1'b1) begin n_err++; $display("FAIL mid_rst_wr0 got %b exp 1", rq0_waitrequest); end
    cyc(); rst_n = 1; rq0_read = 0; #1;
    n_cmp++; if (avm_read !== 1'b0 || avm_addr !== 29'h0 || outstanding !== 3'd0) begin n_err++; $display("FAIL mid_cleared got %b/%h/%0d exp 0/0/0", avm_read, avm_addr, outstanding); end
    for (int c = 0; c < 3; c++) begin
      cyc(); avm_readdatavalid = 1; #1;
      n_cmp++; if ({rq1_readdatavalid, rq0_readdatavalid} !== 2'b00) begin n_err++; $display("FAIL mid_stray%0d got %b exp 00", c, {rq1_readdatavalid, rq0_readdatavalid}); end
    end
    cyc(); avm_readdatavalid = 0; #1;
    n_cmp++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL mid_occ got %0d exp 0", outstanding); end
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    test_reset();
    test_lone();
    test_contention();
    test_credit();
    test_stall();
    test_same_cycle();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
